mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit. It consumes the outputs of the execute-to-memory pipeline register and performs the data-memory access over a req/gnt/rvalid bus.
- Raises StallM_o to freeze the upstream pipeline registers until the access completes.
- Returns the aligned, sign- or zero-extended load data to the memory-to-writeback register.

---
 rtl/mem_stage_lsu.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid data access per M-stage instruction and stalls upstream until it completes.
// Optional bus watchdog enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int TIMEOUT_CYCLES         = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            ResultSrcM_i,
  input  logic                  MemWriteM_i,
  input  logic [2:0]            Funct3M_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  hold_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  StallM_o,
  output logic                  MisalignM_o,
  output logic                  BusErrM_o
);

  if (DATA_WIDTH != 32 || REGISTER_ADDRESS_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mem_stage_lsu: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    is_load, is_store, mem_op, misalign, access, timeout;
  logic [1:0]              size;
  logic                    we_p0;
  logic [DATA_WIDTH-1:0]   addr_p0, wdata_p0;
  logic [3:0]              be_p0;
  logic [2:0]              funct3_p0;
  logic [1:0]              off_p0;
  logic [DATA_WIDTH-1:0]   rdata_p1;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    unique case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    unique case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    unique case (f3[1:0])
      2'b00: begin
        if (f3[2]) ext = {24'b0, b};
        else       ext = b;
      end
      2'b01: begin
        if (f3[2]) ext = {16'b0, h};
        else       ext = h;
      end
      default: ext = w;
    endcase
    return ext;
  endfunction

  // Decode: Funct3[1:0] selects size; encodings beyond byte/half behave as word.
  assign is_load  = (ResultSrcM_i == 2'b01);
  assign is_store = MemWriteM_i;
  assign mem_op   = is_load | is_store;
  assign size     = Funct3M_i[1:0];

  always_comb begin
    misalign = 1'b0;
    unique case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ALUResultM_i[0];
      default: misalign = |ALUResultM_i[1:0];
    endcase
  end

  assign access      = mem_op & ~misalign;
  assign MisalignM_o = misalign & mem_op;

  always_comb begin
    state_d  = state_q;
    StallM_o = 1'b0;
    unique case (state_q)
      IDLE: if (access) begin
        state_d  = REQ;
        StallM_o = 1'b1;
      end
      REQ: begin
        StallM_o = 1'b1;
        if (mem_gnt_i)    state_d = we_p0 ? DONE : RSP;
        else if (timeout) state_d = DONE;
      end
      RSP: begin
        StallM_o = 1'b1;
        if (mem_rvalid_i || timeout) state_d = DONE;
      end
      DONE: if (!hold_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset must release the upstream pipeline even while an access is presented.
    if (!rst_ni) StallM_o = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Stage p0: request fields latched on issue and held for the whole bus handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_p0     <= 1'b0;
      addr_p0   <= '0;
      be_p0     <= '0;
      wdata_p0  <= '0;
      funct3_p0 <= '0;
      off_p0    <= '0;
    end else if (state_q == IDLE && access) begin
      we_p0     <= is_store;
      addr_p0   <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
      be_p0     <= is_store ? lane_be(size, ALUResultM_i[1:0]) : 4'b1111;
      wdata_p0  <= is_store ? lane_wdata(size, WriteDataM_i) : '0;
      funct3_p0 <= Funct3M_i;
      off_p0    <= ALUResultM_i[1:0];
    end
  end

  // Stage p1: extended load result, stable until the next load response or watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           rdata_p1 <= '0;
    else if (state_q == RSP && mem_rvalid_i) rdata_p1 <= extend_load(mem_rdata_i, funct3_p0, off_p0);
    else if (timeout)                      rdata_p1 <= '0;
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_p0;
  assign mem_addr_o  = addr_p0;
  assign mem_be_o    = be_p0;
  assign mem_wdata_o = wdata_p0;
  assign ReadDataM_o = rdata_p1;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             buserr_q;

  assign timeout = ((state_q == REQ && !mem_gnt_i) || (state_q == RSP && !mem_rvalid_i)) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is zero on the first REQ cycle and keeps running through RSP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      if (state_q == IDLE)                        cnt_q <= '0;
      else if (state_q == REQ || state_q == RSP)  cnt_q <= cnt_q + 1'b1;
      if (timeout)                                buserr_q <= 1'b1;
      else if (state_q == DONE && !hold_i)        buserr_q <= 1'b0;
    end
  end

  assign BusErrM_o = buserr_q;
`else
  assign timeout   = 1'b0;
  assign BusErrM_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: scripted bus responder, transaction-level reference model and per-cycle compare.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  ResultSrcM_i = 2'b00;
  logic        MemWriteM_i = 1'b0;
  logic [2:0]  Funct3M_i = 3'b000;
  logic [31:0] ALUResultM_i = '0;
  logic [31:0] WriteDataM_i = '0;
  logic        hold_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] ReadDataM_o;
  logic        StallM_o, MisalignM_o, BusErrM_o;

  mem_stage_lsu dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ResultSrcM_i(ResultSrcM_i), .MemWriteM_i(MemWriteM_i), .Funct3M_i(Funct3M_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i), .hold_i(hold_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .ReadDataM_o(ReadDataM_o), .StallM_o(StallM_o), .MisalignM_o(MisalignM_o), .BusErrM_o(BusErrM_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: what each instruction must produce on the bus and in ReadDataM.
  function automatic logic m_mis(input logic [1:0] rs, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a);
    logic bad;
    if (f3[1:0] == 2'b00)      bad = 1'b0;
    else if (f3[1:0] == 2'b01) bad = (a % 2) != 0;
    else                       bad = (a % 4) != 0;
    return bad && (rs == 2'b01 || we);
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    if (!we) return 4'hF;
    if (f3[1:0] == 2'b00) return 4'(1 << off);
    if (f3[1:0] == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    longint v;
    int off = int'(a % 4);
    if (f3[1:0] == 2'b00) begin
      v = longint'((w >> (8 * off)) & 32'hFF);
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'b01) begin
      v = longint'((w >> (8 * off)) & 32'hFFFF);
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  logic [31:0] model_rd = '0;

  // Bus responder configuration
  int          cfg_gnt_wait = 0;
  int          cfg_rv_wait  = 0;
  logic        cfg_gnt_en   = 1'b1;
  logic        cfg_ignore   = 1'b0;
  logic [31:0] cfg_rdata    = '0;
  int          gnt_cnt = 0;
  int          rsp_cnt = 0;
  logic        rsp_pending = 1'b0;
  logic        rv_fired = 1'b0;

  always @(negedge clk_i) begin
    mem_rvalid_i = 1'b0;
    if (rsp_pending) begin
      if (rsp_cnt >= cfg_rv_wait) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = cfg_rdata;
        rsp_pending  = 1'b0;
        rv_fired     = 1'b1;
        if (!cfg_ignore) model_rd = m_load(cfg_rdata, Funct3M_i, ALUResultM_i);
      end else begin
        rsp_cnt++;
      end
    end
    mem_gnt_i = 1'b0;
    if (mem_req_o && cfg_gnt_en) begin
      if (gnt_cnt >= cfg_gnt_wait) begin
        mem_gnt_i = 1'b1;
        gnt_cnt   = 0;
        if (!mem_we_o) begin
          rsp_pending = 1'b1;
          rsp_cnt     = 0;
        end
      end else begin
        gnt_cnt++;
      end
    end else if (!mem_req_o) begin
      gnt_cnt = 0;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk_i) begin
    if (rst_ni && cmp_en) begin
      chk("misalign", {31'b0, MisalignM_o},
          {31'b0, m_mis(ResultSrcM_i, MemWriteM_i, Funct3M_i, ALUResultM_i)});
      if (mem_req_o) begin
        chk("req_addr", mem_addr_o, ALUResultM_i & 32'hFFFF_FFFC);
        chk("req_we", {31'b0, mem_we_o}, {31'b0, MemWriteM_i});
        chk("req_be", {28'b0, mem_be_o}, {28'b0, m_be(MemWriteM_i, Funct3M_i, ALUResultM_i)});
        if (MemWriteM_i) chk("req_wdata", mem_wdata_o, m_wdata(Funct3M_i, WriteDataM_i));
      end
      if (!StallM_o) chk("rdata", ReadDataM_o, model_rd);
`ifndef MEM_LSU_TIMEOUT_EN
      chk("buserr_tied", {31'b0, BusErrM_o}, 32'd0);
`endif
    end
  end

  int          stall_n, req_n;
  logic        mis_first;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_we;

  task automatic do_op(input logic [1:0] rs, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    logic done = 1'b0;
    @(posedge clk_i); #1;
    ResultSrcM_i = rs; MemWriteM_i = we; Funct3M_i = f3; ALUResultM_i = a; WriteDataM_i = wd;
    cfg_rdata = rd;
    stall_n = 0; req_n = 0; req_addr = '0; req_be = '0; req_wdata = '0; req_we = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (c == 0) mis_first = MisalignM_o;
      if (mem_req_o) begin
        req_n++;
        req_addr = mem_addr_o; req_be = mem_be_o; req_wdata = mem_wdata_o; req_we = mem_we_o;
      end
      if (!StallM_o) begin
        done = 1'b1;
        break;
      end
      stall_n++;
    end
    if (!done) chk("op_completes", 32'd0, 32'd1);
  endtask

  task automatic finish_op();
    @(posedge clk_i); #1;
    ResultSrcM_i = 2'b00; MemWriteM_i = 1'b0; Funct3M_i = 3'b000;
    ALUResultM_i = '0; WriteDataM_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_stall", {31'b0, StallM_o}, 32'd0);
    chk("rst_buserr", {31'b0, BusErrM_o}, 32'd0);
    chk("rst_rdata", ReadDataM_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_be", {28'b0, mem_be_o}, 32'd0);
    #2 rst_ni = 1'b1;
    cmp_en = 1'b1;

    // LW 0x100, gnt immediately, rvalid next cycle
    do_op(2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF);
    chk("lw_addr", req_addr, 32'h100);
    chk("lw_be", {28'b0, req_be}, 32'hF);
    chk("lw_rdata", ReadDataM_o, 32'hDEADBEEF);
    chk("lw_stall_cycles", stall_n, 32'd3);
    chk("lw_req_cycles", req_n, 32'd1);
    finish_op();

    do_op(2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000);
    chk("lb_rdata", ReadDataM_o, 32'hFFFFFF80);
    finish_op();
    do_op(2'b01, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000);
    chk("lbu_rdata", ReadDataM_o, 32'h00000080);
    finish_op();

    // SB 0x2: completes on gnt without any response
    do_op(2'b00, 1'b1, 3'b000, 32'h2, 32'h000000AB, 32'h0);
    chk("sb_we", {31'b0, req_we}, 32'd1);
    chk("sb_be", {28'b0, req_be}, 32'h4);
    chk("sb_wdata", req_wdata, 32'hABABABAB);
    chk("sb_stall_cycles", stall_n, 32'd2);
    finish_op();

    do_op(2'b00, 1'b1, 3'b001, 32'h2, 32'h00001234, 32'h0);
    chk("sh_be", {28'b0, req_be}, 32'hC);
    chk("sh_wdata", req_wdata, 32'h12341234);
    finish_op();

    // SW with grant withheld for two REQ cycles: request fields must hold
    cfg_gnt_wait = 2;
    do_op(2'b00, 1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 32'h0);
    chk("sw_req_cycles", req_n, 32'd3);
    chk("sw_stall_cycles", stall_n, 32'd4);
    chk("sw_wdata", req_wdata, 32'hCAFEF00D);
    cfg_gnt_wait = 0;
    finish_op();

    // LH/LHU at offset 2 with a slow response
    cfg_rv_wait = 2;
    do_op(2'b01, 1'b0, 3'b001, 32'h2, 32'h0, 32'h80010000);
    chk("lh_rdata", ReadDataM_o, 32'hFFFF8001);
    chk("lh_stall_cycles", stall_n, 32'd5);
    cfg_rv_wait = 0;
    finish_op();
    do_op(2'b01, 1'b0, 3'b101, 32'h2, 32'h0, 32'h80010000);
    chk("lhu_rdata", ReadDataM_o, 32'h00008001);
    finish_op();

    // Misaligned accesses: flagged, no bus, no stall
    do_op(2'b01, 1'b0, 3'b001, 32'h1, 32'h0, 32'h0);
    chk("lh_mis_flag", {31'b0, mis_first}, 32'd1);
    chk("lh_mis_req", req_n, 32'd0);
    chk("lh_mis_stall", stall_n, 32'd0);
    finish_op();
    do_op(2'b00, 1'b1, 3'b010, 32'h102, 32'h5, 32'h0);
    chk("sw_mis_flag", {31'b0, mis_first}, 32'd1);
    chk("sw_mis_req", req_n, 32'd0);
    finish_op();
    do_op(2'b00, 1'b0, 3'b001, 32'h1, 32'h0, 32'h0);
    chk("nonmem_mis_flag", {31'b0, mis_first}, 32'd0);
    chk("nonmem_stall", stall_n, 32'd0);
    finish_op();

    // Completion under hold: stays done, never re-issues
    hold_i = 1'b1;
    do_op(2'b01, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_no_req", {31'b0, mem_req_o}, 32'd0);
      chk("hold_no_stall", {31'b0, StallM_o}, 32'd0);
      chk("hold_rdata", ReadDataM_o, 32'h12345678);
    end
    #1 hold_i = 1'b0;
    finish_op();
    @(negedge clk_i);
    chk("post_hold_req", {31'b0, mem_req_o}, 32'd0);
    chk("post_hold_stall", {31'b0, StallM_o}, 32'd0);

    // Reset in RSP; late rvalid after release must be ignored
    cfg_ignore = 1'b1; cfg_rv_wait = 5; rv_fired = 1'b0;
    @(posedge clk_i); #1;
    ResultSrcM_i = 2'b01; MemWriteM_i = 1'b0; Funct3M_i = 3'b010; ALUResultM_i = 32'h200;
    cfg_rdata = 32'hBADBAD00;
    repeat (3) @(negedge clk_i);
    chk("rsp_stall", {31'b0, StallM_o}, 32'd1);
    #1 rst_ni = 1'b0; model_rd = '0;
    #1;
    chk("midrst_req", {31'b0, mem_req_o}, 32'd0);
    chk("midrst_stall", {31'b0, StallM_o}, 32'd0);
    chk("midrst_rdata", ReadDataM_o, 32'd0);
    chk("midrst_addr", mem_addr_o, 32'd0);
    chk("midrst_be", {28'b0, mem_be_o}, 32'd0);
    chk("midrst_we", {31'b0, mem_we_o}, 32'd0);
    finish_op();
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk("postrst_req", {31'b0, mem_req_o}, 32'd0);
      chk("postrst_stall", {31'b0, StallM_o}, 32'd0);
      chk("postrst_rdata", ReadDataM_o, 32'd0);
    end
    chk("late_rvalid_seen", {31'b0, rv_fired}, 32'd1);
    cfg_ignore = 1'b0; cfg_rv_wait = 0;

    // Unit is back in IDLE and serves a fresh load normally
    do_op(2'b01, 1'b0, 3'b000, 32'h1, 32'h0, 32'h00007F00);
    chk("afterrst_lb", ReadDataM_o, 32'h0000007F);
    finish_op();

`ifdef MEM_LSU_TIMEOUT_EN
    cfg_gnt_en = 1'b0;
    do_op(2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111);
    model_rd = '0;
    chk("to_buserr", {31'b0, BusErrM_o}, 32'd1);
    chk("to_rdata", ReadDataM_o, 32'd0);
    chk("to_req_cycles", req_n, 32'd64);
    chk("to_stall_cycles", stall_n, 32'd65);
    finish_op();
    @(negedge clk_i);
    chk("to_buserr_clears", {31'b0, BusErrM_o}, 32'd0);
    cfg_gnt_en = 1'b1;
`endif

    @(negedge clk_i);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
